or1k_rf_port_arbiter: RTL and testbench
=======================================

Name: or1k_rf_port_arbiter

Overview:
- Sequences and shares the GPR register-file RAM ports between three sources: pipeline writeback, SPR-bus GPR accesses (debug unit / shadow GPRs), and a post-reset clear sweep.
- Owns the single write port feeding all RF RAM copies (rfa/rfb/rfspr) and the rfspr read port.
- Returns a registered acknowledge and read data to the SPR bus.
- Sits between the writeback stage, the SPR bus decoder and the register file.

Parameters:
RF_ADDR_WIDTH, 5, total RF address bits including shadow banks; RF_WORDS = 2**RF_ADDR_WIDTH
OPTION_OPERAND_WIDTH, 32, data width
CLEAR_ON_RESET, 1, nonzero = zero every RF word after reset before releasing the pipeline

Ports:
clk  input  1  clock
rst  input  1  reset
wb_rf_wb_i  input  1  writeback write request this cycle
wb_rfd_adr_i  input  RF_ADDR_WIDTH  writeback destination
wb_result_i  input  OPTION_OPERAND_WIDTH  writeback data
padv_ctrl_i  input  1  ctrl stage advancing; SPR reads are not issued while high
spr_gpr_req_i  input  1  decoded SPR GPR-space strobe; held until ack
spr_gpr_we_i  input  1  1 = write, 0 = read
spr_gpr_adr_i  input  RF_ADDR_WIDTH  GPR index
spr_gpr_dat_i  input  OPTION_OPERAND_WIDTH  SPR write data
spr_gpr_ack_o  output  1  one-cycle acknowledge
spr_gpr_dat_o  output  OPTION_OPERAND_WIDTH  read data, valid with ack, held until next read completes
rf_we_o  output  1  RF write enable
rf_wradr_o  output  RF_ADDR_WIDTH  RF write address
rf_wrdat_o  output  OPTION_OPERAND_WIDTH  RF write data
rf_re_o  output  1  rfspr read enable
rf_radr_o  output  RF_ADDR_WIDTH  rfspr read address
rf_rdat_i  input  OPTION_OPERAND_WIDTH  rfspr read data, valid the cycle after rf_re_o
rf_busy_o  output  1  clear sweep active; pipeline must stall

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high.
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - clear counter = 0; armed = 1.
  - spr_gpr_ack_o = 0; spr_gpr_dat_o = 0; rf_re_o = 0.
  - rf_busy_o = 1 when CLEAR_ON_RESET, else 0.
- Write-port priority: writeback > clear sweep > SPR write.
- When wb_rf_wb_i = 1, the write outputs carry the wb_* values combinationally, regardless of state.
- States: CLEAR, IDLE, WR_PEND, RD_DATA, ACK.
- CLEAR:
  - rf_busy_o = 1.
  - If wb_rf_wb_i = 0: rf_we_o = 1, address = counter, data = 0, counter increments.
  - If wb_rf_wb_i = 1: writeback wins and the counter holds.
  - When a write at counter RF_WORDS-1 completes, next state is IDLE and rf_busy_o drops in the following cycle. The sweep takes exactly RF_WORDS cycles with no writeback.
  - spr_gpr_req_i is ignored in CLEAR.
- IDLE: a request is accepted only when spr_gpr_req_i = 1 and armed = 1.
  - Write, wb_rf_wb_i = 0: the RF write happens in the same cycle; next state ACK.
  - Write, wb_rf_wb_i = 1: latch address and data into the pending buffer; next state WR_PEND.
  - Read with padv_ctrl_i = 0: rf_re_o = 1, rf_radr_o = spr_gpr_adr_i; record whether wb_rf_wb_i is high with wb_rfd_adr_i equal to the read address (collision) and latch wb_result_i; next state RD_DATA.
  - Read with padv_ctrl_i = 1: stay in IDLE and retry next cycle.
- WR_PEND: write the pending buffer on the first cycle with wb_rf_wb_i = 0; next state ACK. There is no upper bound on wait time.
- RD_DATA: spr_gpr_dat_o <= rf_rdat_i, or the forwarded value (see Optional Feature); next state ACK.
- ACK: spr_gpr_ack_o = 1 for exactly this cycle; armed <= 0; next state IDLE.
- Re-arming: armed returns to 1 on any cycle where spr_gpr_req_i = 0. Bus masters drop strobe the cycle after ack, so a lingering strobe is never re-accepted.
- Ack latency from acceptance: write 1 cycle (no collision); read 2 cycles.
- Reset asserted mid-operation: abandons any pending write (not performed), suppresses ack and restarts the CLEAR sweep from 0.
- Address width: RF_ADDR_WIDTH wraps naturally; the counter terminal compare is against all-ones.

Optional Feature:
- Macro: OR1K_RF_ARB_RD_FWD_EN.
- Defined: a read whose issue cycle collides with a writeback to the same address returns the latched writeback data in RD_DATA. Latency is unchanged.
- Undefined: a colliding read is discarded in RD_DATA and reissued (return to the IDLE issue path, armed kept at 1). Data is always taken from the RAM; latency grows by 2 cycles per collision.

Test Plan:
- Reset with CLEAR_ON_RESET=1, RF_ADDR_WIDTH=5, no writeback -> rf_we_o high for 32 cycles at addresses 0..31 with data 0; rf_busy_o low from cycle 33; no ack during the sweep.
- Sweep with wb_rf_wb_i=1, adr 7, data 0x1234 injected at sweep count 10 -> that cycle writes addr 7 / 0x1234, the counter holds at 10, and the sweep ends one cycle later (33 cycles).
- IDLE SPR write adr 3, data 0xDEADBEEF, no wb -> write at addr 3 in the accept cycle, ack the next cycle, single ack even if req is held 1 extra cycle.
- SPR write adr 4 while wb writes adr 9 for 3 consecutive cycles -> RAM write to 4 on cycle 4, ack on cycle 5; all wb writes intact.
- SPR read adr 5 (RAM holds 0x55) with padv_ctrl_i=1 for 2 cycles, then 0 -> rf_re_o issues on cycle 3, ack with dat 0x55 on cycle 5.
- SPR read adr 6 colliding with wb adr 6, data 0xA5A5A5A5 -> with OR1K_RF_ARB_RD_FWD_EN: ack 2 cycles later with 0xA5A5A5A5; without it: reissue, ack 4 cycles later with the RAM value 0xA5A5A5A5.

Source files
------------

// File: rtl/or1k_rf_port_arbiter.sv
// GPR register-file port arbiter: shares the RF write port between writeback, the post-reset clear sweep and SPR-bus accesses.
// Define OR1K_RF_ARB_RD_FWD_EN to forward colliding writeback data to SPR reads instead of reissuing them.
module or1k_rf_port_arbiter #(
  parameter int RF_ADDR_WIDTH        = 5,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int CLEAR_ON_RESET       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_wb_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wb_result_i,
  input  logic                            padv_ctrl_i,
  input  logic                            spr_gpr_req_i,
  input  logic                            spr_gpr_we_i,
  input  logic [RF_ADDR_WIDTH-1:0]        spr_gpr_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  output logic                            rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            rf_re_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_radr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_rdat_i,
  output logic                            rf_busy_o
);

  typedef enum logic [2:0] {CLEAR, IDLE, WR_PEND, RD_DATA, ACK} state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t                          state, state_next;
  logic [RF_ADDR_WIDTH-1:0]        clr_cnt;
  logic                            armed;
  logic [RF_ADDR_WIDTH-1:0]        pend_adr;
  logic [OPTION_OPERAND_WIDTH-1:0] pend_dat;
  logic                            rd_col;
  logic [OPTION_OPERAND_WIDTH-1:0] dat_q;
  logic                            accept;
  logic                            clr_inc;
  logic                            pend_load;
  logic                            rd_issue;
  logic                            rd_capture;
`ifdef OR1K_RF_ARB_RD_FWD_EN
  logic [OPTION_OPERAND_WIDTH-1:0] fwd_dat;
`endif

  assign accept        = spr_gpr_req_i & armed;
  assign spr_gpr_ack_o = ~rst & (state == ACK);
  assign spr_gpr_dat_o = dat_q;
  assign rf_busy_o     = rst ? (CLEAR_ON_RESET != 0) : (state == CLEAR);

  // Writeback always owns the write port; other sources only use it on idle writeback cycles.
  always_comb begin
    state_next = state;
    rf_we_o    = wb_rf_wb_i;
    rf_wradr_o = wb_rfd_adr_i;
    rf_wrdat_o = wb_result_i;
    rf_re_o    = 1'b0;
    rf_radr_o  = spr_gpr_adr_i;
    clr_inc    = 1'b0;
    pend_load  = 1'b0;
    rd_issue   = 1'b0;
    rd_capture = 1'b0;

    case (state)
      CLEAR: begin
        if (!wb_rf_wb_i) begin
          rf_we_o    = 1'b1;
          rf_wradr_o = clr_cnt;
          rf_wrdat_o = '0;
          clr_inc    = 1'b1;
          if (clr_cnt == '1)
            state_next = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          if (spr_gpr_we_i) begin
            if (!wb_rf_wb_i) begin
              rf_we_o    = 1'b1;
              rf_wradr_o = spr_gpr_adr_i;
              rf_wrdat_o = spr_gpr_dat_i;
              state_next = ACK;
            end else begin
              pend_load  = 1'b1;
              state_next = WR_PEND;
            end
          end else if (!padv_ctrl_i) begin
            rf_re_o    = 1'b1;
            rd_issue   = 1'b1;
            state_next = RD_DATA;
          end
        end
      end
      WR_PEND: begin
        if (!wb_rf_wb_i) begin
          rf_we_o    = 1'b1;
          rf_wradr_o = pend_adr;
          rf_wrdat_o = pend_dat;
          state_next = ACK;
        end
      end
      RD_DATA: begin
`ifdef OR1K_RF_ARB_RD_FWD_EN
        rd_capture = 1'b1;
        state_next = ACK;
`else
        // The RAM returned pre-writeback data, so drop it and issue the read again.
        if (rd_col) begin
          state_next = IDLE;
        end else begin
          rd_capture = 1'b1;
          state_next = ACK;
        end
`endif
      end
      ACK:     state_next = IDLE;
      default: state_next = RESET_STATE;
    endcase

    if (rst) begin
      rf_we_o    = wb_rf_wb_i;
      rf_wradr_o = wb_rfd_adr_i;
      rf_wrdat_o = wb_result_i;
      rf_re_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_STATE;
      clr_cnt  <= '0;
      armed    <= 1'b1;
      pend_adr <= '0;
      pend_dat <= '0;
      rd_col   <= 1'b0;
      dat_q    <= '0;
`ifdef OR1K_RF_ARB_RD_FWD_EN
      fwd_dat  <= '0;
`endif
    end else begin
      state <= state_next;
      if (clr_inc)
        clr_cnt <= clr_cnt + 1'b1;
      if (pend_load) begin
        pend_adr <= spr_gpr_adr_i;
        pend_dat <= spr_gpr_dat_i;
      end
      if (rd_issue) begin
        rd_col <= wb_rf_wb_i & (wb_rfd_adr_i == spr_gpr_adr_i);
`ifdef OR1K_RF_ARB_RD_FWD_EN
        fwd_dat <= wb_result_i;
`endif
      end
      if (rd_capture) begin
`ifdef OR1K_RF_ARB_RD_FWD_EN
        dat_q <= rd_col ? fwd_dat : rf_rdat_i;
`else
        dat_q <= rf_rdat_i;
`endif
      end
      // A strobe still high after ack belongs to the finished access and must not be re-accepted.
      if (!spr_gpr_req_i)
        armed <= 1'b1;
      else if (state == ACK)
        armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_or1k_rf_port_arbiter.sv
// Directed testbench for or1k_rf_port_arbiter: vector table for the SPR access paths plus hand-written reset/sweep/collision sequences.
module tb_or1k_rf_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_rf_wb_i;
  logic [4:0]  wb_rfd_adr_i;
  logic [31:0] wb_result_i;
  logic        padv_ctrl_i;
  logic        spr_gpr_req_i;
  logic        spr_gpr_we_i;
  logic [4:0]  spr_gpr_adr_i;
  logic [31:0] spr_gpr_dat_i;
  logic        spr_gpr_ack_o;
  logic [31:0] spr_gpr_dat_o;
  logic        rf_we_o;
  logic [4:0]  rf_wradr_o;
  logic [31:0] rf_wrdat_o;
  logic        rf_re_o;
  logic [4:0]  rf_radr_o;
  logic [31:0] rf_rdat_i;
  logic        rf_busy_o;

  logic [31:0] mem [32];

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        wb;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        padv;
    logic        req;
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_re;
    logic [4:0]  e_ra;
    logic        e_ack;
    logic [31:0] e_dat;
    logic        e_busy;
  } vec_t;

  vec_t vecs [22];

  or1k_rf_port_arbiter #(
    .RF_ADDR_WIDTH(5),
    .OPTION_OPERAND_WIDTH(32),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_rf_wb_i(wb_rf_wb_i),
    .wb_rfd_adr_i(wb_rfd_adr_i),
    .wb_result_i(wb_result_i),
    .padv_ctrl_i(padv_ctrl_i),
    .spr_gpr_req_i(spr_gpr_req_i),
    .spr_gpr_we_i(spr_gpr_we_i),
    .spr_gpr_adr_i(spr_gpr_adr_i),
    .spr_gpr_dat_i(spr_gpr_dat_i),
    .spr_gpr_ack_o(spr_gpr_ack_o),
    .spr_gpr_dat_o(spr_gpr_dat_o),
    .rf_we_o(rf_we_o),
    .rf_wradr_o(rf_wradr_o),
    .rf_wrdat_o(rf_wrdat_o),
    .rf_re_o(rf_re_o),
    .rf_radr_o(rf_radr_o),
    .rf_rdat_i(rf_rdat_i),
    .rf_busy_o(rf_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RF RAM with read-before-write behaviour.
  always @(posedge clk) begin
    if (rf_we_o)
      mem[rf_wradr_o] <= rf_wrdat_o;
    if (rf_re_o)
      rf_rdat_i <= mem[rf_radr_o];
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wb, input logic [4:0] wba, input logic [31:0] wbd,
                               input logic padv, input logic req, input logic we,
                               input logic [4:0] adr, input logic [31:0] dat);
    wb_rf_wb_i    = wb;
    wb_rfd_adr_i  = wba;
    wb_result_i   = wbd;
    padv_ctrl_i   = padv;
    spr_gpr_req_i = req;
    spr_gpr_we_i  = we;
    spr_gpr_adr_i = adr;
    spr_gpr_dat_i = dat;
  endtask

  task automatic checkOutput(input string tag, input logic e_we, input logic [4:0] e_wa,
                             input logic [31:0] e_wd, input logic e_re, input logic [4:0] e_ra,
                             input logic e_ack, input logic [31:0] e_dat, input logic e_busy);
    #2;
    checkValue({tag, ".we"}, {31'd0, rf_we_o}, {31'd0, e_we});
    if (e_we) begin
      checkValue({tag, ".wradr"}, {27'd0, rf_wradr_o}, {27'd0, e_wa});
      checkValue({tag, ".wrdat"}, rf_wrdat_o, e_wd);
    end
    checkValue({tag, ".re"}, {31'd0, rf_re_o}, {31'd0, e_re});
    if (e_re)
      checkValue({tag, ".radr"}, {27'd0, rf_radr_o}, {27'd0, e_ra});
    checkValue({tag, ".ack"}, {31'd0, spr_gpr_ack_o}, {31'd0, e_ack});
    checkValue({tag, ".dat"}, spr_gpr_dat_o, e_dat);
    checkValue({tag, ".busy"}, {31'd0, rf_busy_o}, {31'd0, e_busy});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // wb wba wbd padv req we adr dat | e_we e_wa e_wd e_re e_ra e_ack e_dat e_busy
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 32'h0,  1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[5]  = '{1'b1, 5'd9, 32'h99,       1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[6]  = '{1'b1, 5'd9, 32'h98,       1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b1, 5'd9, 32'h98,       1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[7]  = '{1'b1, 5'd9, 32'h97,       1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b1, 5'd9, 32'h97,       1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 32'h0,  1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[11] = '{1'b1, 5'd5, 32'h55,       1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h55,       1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 32'h0,  1'b0};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,  1'b0};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 32'h55, 1'b0};
    vecs[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h55, 1'b0};
    vecs[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd4, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 32'h55, 1'b0};
    vecs[19] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd4, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h55, 1'b0};
    vecs[20] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd4, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 32'h44, 1'b0};
    vecs[21] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h44, 1'b0};

    // Reset, then a clean sweep with an SPR read strobe held (must be ignored).
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    nextCycle();
    checkOutput("reset", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    nextCycle();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, (k < 31), 1'b0, 5'd2, 32'h0);
      checkOutput($sformatf("sweep%0d", k), 1'b1, k[4:0], 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("sweep_end", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    nextCycle();

    // Sweep with a writeback injected at count 10.
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int k = 0; k < 33; k++) begin
      logic [4:0] ea;
      logic [31:0] ed;
      ea = (k < 10) ? k[4:0] : (k == 10) ? 5'd7 : 5'(k - 1);
      ed = (k == 10) ? 32'h1234 : 32'h0;
      applyStimulus((k == 10), 5'd7, 32'h1234, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkOutput($sformatf("wbsweep%0d", k), 1'b1, ea, ed, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("wbsweep_end", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    checkValue("mem7", mem[7], 32'h1234);
    checkValue("mem31", mem[31], 32'h0);
    nextCycle();

    // Vector table: SPR writes, delayed write, stalled read.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].wb, vecs[i].wba, vecs[i].wbd, vecs[i].padv,
                    vecs[i].req, vecs[i].we, vecs[i].adr, vecs[i].dat);
      checkOutput($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd,
                  vecs[i].e_re, vecs[i].e_ra, vecs[i].e_ack, vecs[i].e_dat, vecs[i].e_busy);
      nextCycle();
    end
    checkValue("mem3", mem[3], 32'hDEADBEEF);
    checkValue("mem9", mem[9], 32'h97);

    // Read colliding with a writeback to the same address.
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("col_pre", 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 1'b0, 32'h44, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd6, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0);
    checkOutput("col_issue", 1'b1, 5'd6, 32'hA5A5A5A5, 1'b1, 5'd6, 1'b0, 32'h44, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0);
    checkOutput("col_c1", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h44, 1'b0);
    nextCycle();
`ifdef OR1K_RF_ARB_RD_FWD_EN
    checkOutput("col_ack", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA5A5A5A5, 1'b0);
    nextCycle();
`else
    checkOutput("col_reissue", 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 32'h44, 1'b0);
    nextCycle();
    checkOutput("col_c3", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h44, 1'b0);
    nextCycle();
    checkOutput("col_ack", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA5A5A5A5, 1'b0);
    nextCycle();
`endif
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("col_done", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hA5A5A5A5, 1'b0);
    nextCycle();

    // Reset while a write is pending: write dropped, no ack, sweep restarts at 0.
    applyStimulus(1'b1, 5'd10, 32'hAA, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22);
    checkOutput("mr_accept", 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0, 1'b0, 32'hA5A5A5A5, 1'b0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22);
    checkOutput("mr_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hA5A5A5A5, 1'b1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 32; k++) begin
      checkOutput($sformatf("mr_sweep%0d", k), 1'b1, k[4:0], 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
      nextCycle();
    end
    checkOutput("mr_end", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    checkValue("mr_mem2", mem[2], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
